mem_stage_dmem_ctrl: RTL

Data-memory responder for the MEM stage of the pipelined core. It consumes the memory request carried out of the EX/MEM pipeline register: read/write strobes, ALU result as address, and second register-file operand as store data. It serves each request from an internal word array with a fixed multi-cycle latency. It stalls the pipeline while an access is in flight and presents load data for the MEM/WB register.

---
 rtl/mem_stage_dmem_ctrl_pkg.sv | 15 +
 rtl/mem_stage_dmem_ctrl_if.sv | 23 ++
 rtl/mem_stage_dmem_ctrl_dmem_array.sv | 20 ++
 rtl/mem_stage_dmem_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/mem_stage_dmem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WORD_LEN = 16;
  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_LATENCY  = 2;
  localparam int CNT_W        = 4;

endpackage

// File: rtl/mem_stage_dmem_ctrl_if.sv
// Request/response bundle between the EX/MEM register and the data-memory responder.
interface mem_stage_dmem_ctrl_if #(
  parameter int WORD_LEN = 16
);
  logic                MEM_read;
  logic                MEM_write;
  logic [WORD_LEN-1:0] addr;
  logic [WORD_LEN-1:0] wdata;
  logic                stall;
  logic [WORD_LEN-1:0] rdata;
  logic                rdata_valid;
  logic                err;

  modport master (
    output MEM_read, MEM_write, addr, wdata,
    input  stall, rdata, rdata_valid, err
  );

  modport slave (
    input  MEM_read, MEM_write, addr, wdata,
    output stall, rdata, rdata_valid, err
  );
endinterface

// File: rtl/mem_stage_dmem_ctrl_dmem_array.sv
// Single-port synchronous word RAM: write and registered read share one edge, no reset.
module dmem_array #(
  parameter int WORD_LEN = 16,
  parameter int ADDR_W   = 8
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [WORD_LEN-1:0] wdata,
  output logic [WORD_LEN-1:0] rdata
);

  logic [WORD_LEN-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/mem_stage_dmem_ctrl.sv
// MEM-stage data-memory responder: fixed-latency loads/stores with pipeline stall.
module mem_stage_dmem_ctrl
  import mem_stage_pkg::*;
#(
  parameter int WORD_LEN = DEF_WORD_LEN,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int LATENCY  = DEF_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_stage_dmem_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                is_store_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_LEN-1:0] wdata_q;
  logic [WORD_LEN-1:0] rdata_q;
  logic [WORD_LEN-1:0] ram_rdata;

  logic                req_one, req_both, accept;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [WORD_LEN-1:0] ram_wdata;
  logic                stall, err, rdata_valid;
  logic [WORD_LEN-1:0] rdata;
  logic                unused_addr_hi;

  assign req_one        = bus.MEM_read ^ bus.MEM_write;
  assign req_both       = bus.MEM_read & bus.MEM_write;
  assign accept         = (state_q == IDLE) && req_one && !rst;
  assign unused_addr_hi = ^bus.addr[WORD_LEN-1:ADDR_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == DONE && !is_store_q) rdata_q <= ram_rdata;
    end
  end

  // Request copies are frozen at accept so BUSY ignores the live inputs.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_store_q <= bus.MEM_write;
      addr_q     <= bus.addr[ADDR_W-1:0];
      wdata_q    <= bus.wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_one) begin
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY > 1) ? BUSY : DONE;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The RAM is strobed on the edge that enters DONE; with LATENCY=1 that is the accept edge.
  always_comb begin
    stall       = 1'b0;
    err         = 1'b0;
    rdata_valid = 1'b0;
    rdata       = rdata_q;
    ram_we      = 1'b0;
    ram_addr    = addr_q;
    ram_wdata   = wdata_q;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          ram_addr  = bus.addr[ADDR_W-1:0];
          ram_wdata = bus.wdata;
          stall     = req_one;
          err       = req_both;
          ram_we    = (LATENCY == 1) && req_one && bus.MEM_write;
        end
        BUSY: begin
          stall  = 1'b1;
          ram_we = is_store_q && (cnt_q == CNT_ONE);
        end
        DONE: begin
          rdata_valid = !is_store_q;
          if (!is_store_q) rdata = ram_rdata;
        end
        default: ;
      endcase
    end
  end

  assign bus.stall       = stall;
  assign bus.err         = err;
  assign bus.rdata_valid = rdata_valid;
  assign bus.rdata       = rdata;

  dmem_array #(
    .WORD_LEN (WORD_LEN),
    .ADDR_W   (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule
